// File: rtl/ooo_issue_queue.sv
// Out-of-order issue queue: collapsing age-ordered storage with tag wakeup,
// oldest-ready select, valid/ready issue and redirect flush.
module ooo_issue_queue #(
    parameter int DATA_WIDTH = 47,
    parameter int PR_ADDR_W  = 6,
    parameter int NUM_SRC    = 2,
    parameter int PUSH_WIDTH = 2,
    parameter int DEPTH      = 8,
    parameter int WAKE_WIDTH = 6
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    flush,
    input  logic [PUSH_WIDTH*DATA_WIDTH-1:0]        din,
    input  logic [PUSH_WIDTH*NUM_SRC*PR_ADDR_W-1:0] din_src,
    input  logic [PUSH_WIDTH-1:0]                   din_valid,
    output logic [PUSH_WIDTH-1:0]                   din_ready,
    input  logic [WAKE_WIDTH*PR_ADDR_W-1:0]         wake_tag,
    input  logic [WAKE_WIDTH-1:0]                   wake_valid,
    output logic [DATA_WIDTH-1:0]                   dout,
    output logic                                    dout_valid,
    input  logic                                    dout_ready,
    output logic [$clog2(DEPTH+1)-1:0]              count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] data_r [DEPTH];
    logic [PR_ADDR_W-1:0]  tag_r  [DEPTH][NUM_SRC];
    logic [NUM_SRC-1:0]    rdy_r  [DEPTH];
    logic [CNT_W-1:0]      count_r;

    logic [DATA_WIDTH-1:0] data_s [DEPTH];
    logic [PR_ADDR_W-1:0]  tag_s  [DEPTH][NUM_SRC];
    logic [NUM_SRC-1:0]    rdy_s  [DEPTH];
    logic [CNT_W-1:0]      count_s;

    logic [DEPTH-1:0]      elig_s;
    logic [IDX_W-1:0]      sel_idx_s;
    logic                  sel_found_s;
    logic                  pop_s;
    logic [CNT_W-1:0]      base_s;
    logic [CNT_W-1:0]      push_cnt_s;
    logic [IDX_W-1:0]      slot_s;

    function automatic logic tag_woken(
        input logic [PR_ADDR_W-1:0]            tag,
        input logic [WAKE_WIDTH*PR_ADDR_W-1:0] tags,
        input logic [WAKE_WIDTH-1:0]           vld
    );
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WAKE_WIDTH; w++) begin
            hit = hit | (vld[w] & (tags[w*PR_ADDR_W +: PR_ADDR_W] == tag));
        end
        return hit;
    endfunction

    // Oldest-ready select: scan downward so the lowest eligible index wins
    always_comb begin
        elig_s      = '0;
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            elig_s[i]   = (i < int'(count_r)) && (&rdy_r[i]);
            sel_found_s = sel_found_s | elig_s[i];
            sel_idx_s   = elig_s[i] ? IDX_W'(i) : sel_idx_s;
        end
    end

    assign dout_valid = sel_found_s;
    assign dout       = data_r[sel_idx_s];
    assign count      = count_r;
    assign pop_s      = sel_found_s & dout_ready & ~flush;

    // Lane acceptance from registered occupancy only
    always_comb begin
        din_ready = '0;
        for (int l = 0; l < PUSH_WIDTH; l++) begin
            din_ready[l] = !flush && ((DEPTH - int'(count_r)) > l);
        end
    end

    // Next state: wakeup, collapse above the popped slot, then append pushes
    always_comb begin
        data_s     = data_r;
        tag_s      = tag_r;
        rdy_s      = rdy_r;
        base_s     = count_r - CNT_W'(pop_s);
        push_cnt_s = '0;
        slot_s     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                rdy_s[i][s] = rdy_r[i][s] | tag_woken(tag_r[i][s], wake_tag, wake_valid);
            end
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            data_s[i] = (pop_s && (IDX_W'(i) >= sel_idx_s)) ? data_s[i+1] : data_s[i];
            tag_s[i]  = (pop_s && (IDX_W'(i) >= sel_idx_s)) ? tag_s[i+1]  : tag_s[i];
            rdy_s[i]  = (pop_s && (IDX_W'(i) >= sel_idx_s)) ? rdy_s[i+1]  : rdy_s[i];
        end
        for (int l = 0; l < PUSH_WIDTH; l++) begin
            slot_s = IDX_W'(base_s + push_cnt_s);
            if (din_valid[l] && din_ready[l]) begin
                data_s[slot_s] = din[l*DATA_WIDTH +: DATA_WIDTH];
                for (int s = 0; s < NUM_SRC; s++) begin
                    tag_s[slot_s][s] = din_src[(l*NUM_SRC+s)*PR_ADDR_W +: PR_ADDR_W];
                    rdy_s[slot_s][s] = (din_src[(l*NUM_SRC+s)*PR_ADDR_W +: PR_ADDR_W] < PR_ADDR_W'(2))
                                     | tag_woken(din_src[(l*NUM_SRC+s)*PR_ADDR_W +: PR_ADDR_W],
                                                 wake_tag, wake_valid);
                end
                push_cnt_s = push_cnt_s + CNT_W'(1);
            end else begin
                push_cnt_s = push_cnt_s;
            end
        end
        count_s = flush ? '0 : (base_s + push_cnt_s);
    end

    // Entry storage and occupancy, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= '0;
                rdy_r[i]  <= '0;
                for (int s = 0; s < NUM_SRC; s++) begin
                    tag_r[i][s] <= '0;
                end
            end
        end else begin
            count_r <= count_s;
            data_r  <= data_s;
            tag_r   <= tag_s;
            rdy_r   <= rdy_s;
        end
    end
endmodule

// File: tb/tb_ooo_issue_queue.sv
// Self-checking bench for ooo_issue_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_ooo_issue_queue;
    localparam int DW = 47, AW = 6, NS = 2, PW = 2, DP = 8, WW = 6;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] t1;
        logic [AW-1:0] t0;
        logic          r1;
        logic          r0;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [PW*DW-1:0]  din = '0;
    logic [PW*NS*AW-1:0] din_src = '0;
    logic [PW-1:0]     din_valid = '0;
    logic [PW-1:0]     din_ready;
    logic [WW*AW-1:0]  wake_tag = '0;
    logic [WW-1:0]     wake_valid = '0;
    logic [DW-1:0]     dout;
    logic              dout_valid;
    logic              dout_ready = 1'b0;
    logic [3:0]        count;

    ent_t q[$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ooo_issue_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .din_src(din_src),
        .din_valid(din_valid), .din_ready(din_ready), .wake_tag(wake_tag),
        .wake_valid(wake_valid), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .count(count)
    );

    function automatic logic [DW-1:0] rp();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[DW-1:0];
    endfunction

    function automatic bit woken(input logic [AW-1:0] t);
        for (int w = 0; w < WW; w++)
            if (wake_valid[w] && wake_tag[w*AW +: AW] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_sel();
        for (int i = 0; i < q.size(); i++)
            if (q[i].r0 && q[i].r1) return i;
        return -1;
    endfunction

    task automatic idle();
        din_valid = '0; wake_valid = '0; dout_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic [DW-1:0] p,
                            input logic [AW-1:0] t0, input logic [AW-1:0] t1);
        din[l*DW +: DW] = p;
        din_src[(l*NS)*AW +: AW] = t0;
        din_src[(l*NS+1)*AW +: AW] = t1;
        din_valid[l] = 1'b1;
    endtask

    task automatic wake(input int w, input logic [AW-1:0] t);
        wake_tag[w*AW +: AW] = t;
        wake_valid[w] = 1'b1;
    endtask

    // Advance one clock and apply the behavioural rules to the model
    task automatic tick();
        @(posedge clk);
        if (!rst_n || flush) q.delete();
        else begin
            int sel = m_sel();
            int cnt0 = q.size();
            for (int i = 0; i < q.size(); i++) begin
                q[i].r0 = q[i].r0 | woken(q[i].t0);
                q[i].r1 = q[i].r1 | woken(q[i].t1);
            end
            if (sel >= 0 && dout_ready) q.delete(sel);
            for (int l = 0; l < PW; l++) begin
                if (din_valid[l] && (DP - cnt0) > l) begin
                    ent_t e;
                    e.d  = din[l*DW +: DW];
                    e.t0 = din_src[(l*NS)*AW +: AW];
                    e.t1 = din_src[(l*NS+1)*AW +: AW];
                    e.r0 = (e.t0 < 2) || woken(e.t0);
                    e.r1 = (e.t1 < 2) || woken(e.t1);
                    q.push_back(e);
                end
            end
        end
        #2;
    endtask

    task automatic test_reset();
        idle();
        for (int c = 0; c < 3; c++) begin
            set_lane(0, rp(), 6'd40, 6'd41);
            if (c < 2) set_lane(1, rp(), 6'd42, 6'd43);
            tick(); idle();
        end
        #1;
        n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL reset_precount: got %0d want 5", count); end
        rst_n = 1'b0; q.delete(); #1;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
        n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
        tick(); rst_n = 1'b1; #1;
        n_checks++; if (din_ready !== 2'b11) begin n_fail++; $display("FAIL reset_din_ready: got %b want 11", din_ready); end
    endtask

    task automatic test_basic_issue();
        logic [DW-1:0] p;
        idle(); p = rp(); set_lane(0, p, 6'd0, 6'd1); #1;
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_same_cycle: got %b want 0", dout_valid); end
        tick(); idle(); #1;
        n_checks++; if (dout_valid !== 1'b1 || dout !== p) begin n_fail++; $display("FAIL basic_issue: got %b/%h want 1/%h", dout_valid, dout, p); end
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", count); end
        dout_ready = 1'b1; tick(); idle(); #1;
        n_checks++; if (count !== 4'd0 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop: got %0d/%b want 0/0", count, dout_valid); end
    endtask

    task automatic test_ooo();
        logic [DW-1:0] a, b;
        a = rp(); b = rp(); idle();
        set_lane(0, a, 6'd9, 6'd1); tick(); idle();
        set_lane(0, b, 6'd0, 6'd1); tick(); idle(); #1;
        n_checks++; if (dout_valid !== 1'b1 || dout !== b) begin n_fail++; $display("FAIL ooo_b_first: got %b/%h want 1/%h", dout_valid, dout, b); end
        dout_ready = 1'b1; tick(); idle();
        wake(2, 6'd9); #1;
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_wake_latency: got %b want 0", dout_valid); end
        tick(); idle(); #1;
        n_checks++; if (dout_valid !== 1'b1 || dout !== a) begin n_fail++; $display("FAIL ooo_a_woken: got %b/%h want 1/%h", dout_valid, dout, a); end
        dout_ready = 1'b1; tick(); idle(); #1;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL ooo_drain: got %0d want 0", count); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] p;
        p = rp(); idle();
        set_lane(0, p, 6'd12, 6'd13); wake(0, 6'd12); wake(5, 6'd13);
        tick(); idle(); #1;
        n_checks++; if (dout_valid !== 1'b1 || dout !== p) begin n_fail++; $display("FAIL bypass_issue: got %b/%h want 1/%h", dout_valid, dout, p); end
        dout_ready = 1'b1; tick(); idle();
    endtask

    task automatic test_full();
        logic [DW-1:0] first;
        first = rp(); idle();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) set_lane(0, first, 6'd0, 6'd1);
            else set_lane(0, rp(), 6'd50, 6'd51);
            set_lane(1, rp(), 6'd50, 6'd51);
            tick(); idle();
        end
        #1;
        n_checks++; if (count !== 4'd8 || din_ready !== 2'b00) begin n_fail++; $display("FAIL full_state: got %0d/%b want 8/00", count, din_ready); end
        dout_ready = 1'b1; set_lane(0, rp(), 6'd0, 6'd1); set_lane(1, rp(), 6'd0, 6'd1); #1;
        n_checks++; if (din_ready !== 2'b00 || dout !== first) begin n_fail++; $display("FAIL full_poppush: got %b/%h want 00/%h", din_ready, dout, first); end
        tick(); idle(); #1;
        n_checks++; if (count !== 4'd7) begin n_fail++; $display("FAIL full_after_pop: got %0d want 7", count); end
        flush = 1'b1; tick(); idle();
    endtask

    task automatic test_collapse_flush();
        logic [DW-1:0] pay [8];
        logic [DW-1:0] exp_order [7];
        int lane;
        idle();
        for (int i = 0; i < 8; i++) pay[i] = rp();
        for (int i = 0; i < 6; i++) begin
            lane = (i < 4) ? (i % 2) : 1;
            set_lane(lane, pay[i], (i == 2) ? 6'd0 : 6'd50, 6'd1);
            if (lane == 1) begin tick(); idle(); end
        end
        #1;
        n_checks++; if (count !== 4'd6 || dout !== pay[2]) begin n_fail++; $display("FAIL collapse_pre: got %0d/%h want 6/%h", count, dout, pay[2]); end
        dout_ready = 1'b1; set_lane(0, pay[6], 6'd50, 6'd1); set_lane(1, pay[7], 6'd50, 6'd1);
        tick(); idle(); #1;
        n_checks++; if (count !== 4'd7 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL collapse_post: got %0d/%b want 7/0", count, dout_valid); end
        exp_order = '{pay[0], pay[1], pay[3], pay[4], pay[5], pay[6], pay[7]};
        wake(0, 6'd50); tick(); idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (dout_valid !== 1'b1 || dout !== exp_order[k]) begin n_fail++; $display("FAIL collapse_order%0d: got %b/%h want 1/%h", k, dout_valid, dout, exp_order[k]); end
            dout_ready = 1'b1; tick(); idle();
        end
        flush = 1'b1; set_lane(0, rp(), 6'd0, 6'd1); set_lane(1, rp(), 6'd0, 6'd1); #1;
        n_checks++; if (din_ready !== 2'b00) begin n_fail++; $display("FAIL flush_ready: got %b want 00", din_ready); end
        tick(); idle(); #1;
        n_checks++; if (count !== 4'd0 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %0d/%b want 0/0", count, dout_valid); end
    endtask

    task automatic test_random();
        int sel;
        logic [1:0] er;
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int l = 0; l < PW; l++)
                if ($urandom_range(0, 2) != 0)
                    set_lane(l, rp(), AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
            for (int w = 0; w < WW; w++)
                if ($urandom_range(0, 3) == 0) wake(w, AW'($urandom_range(0, 15)));
            dout_ready = ($urandom_range(0, 1) == 1);
            flush = ($urandom_range(0, 39) == 0);
            #1;
            sel = m_sel();
            for (int l = 0; l < PW; l++) er[l] = !flush && ((DP - q.size()) > l);
            n_checks++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL rand_count c%0d: got %0d want %0d", c, count, q.size()); end
            n_checks++; if (dout_valid !== (sel >= 0)) begin n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", c, dout_valid, sel >= 0); end
            if (sel >= 0) begin
                n_checks++; if (dout !== q[sel].d) begin n_fail++; $display("FAIL rand_dout c%0d: got %h want %h", c, dout, q[sel].d); end
            end
            n_checks++; if (din_ready !== er) begin n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, din_ready, er); end
            tick();
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        idle();
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        tick();
        test_reset();
        test_basic_issue();
        test_ooo();
        test_bypass();
        test_full();
        test_collapse_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
